// File: rtl/ula_wb_flags.sv
`default_nettype none
// ============================================================================
//  Module   : ula_wb_flags
//  Purpose  : Writeback / flag-register stage behind the arithmetic ULA.
//             2-entry skid buffer (valid/ready), O/C/S/Z flag register,
//             branch condition evaluation and retired-operation counter.
//  Revision : 1.0  initial release
// ============================================================================
module ula_wb_flags #(
   parameter int bits   = 32,
   parameter int DEST_W = 4,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [bits-1:0]   RESU,
   input  logic [4:0]        OP,
   input  logic              O,
   input  logic              C,
   input  logic              S,
   input  logic              Z,
   input  logic [DEST_W-1:0] DEST,
   input  logic              WE_IN,
   input  logic              FLAG_EN,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [bits-1:0]   WB_DATA,
   output logic [DEST_W-1:0] WB_DEST,
   output logic              WB_WE,
   output logic [3:0]        FLAGS,
   input  logic [3:0]        COND,
   output logic              COND_TRUE,
   output logic              ERR,
   output logic [CNT_W-1:0]  OP_CNT
);

   // Buffer occupancy states
   localparam logic [1:0] c_st_empty = 2'd0;
   localparam logic [1:0] c_st_one   = 2'd1;
   localparam logic [1:0] c_st_two   = 2'd2;

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic              r_in_ready;

   logic [bits-1:0]   r_main_data;
   logic [DEST_W-1:0] r_main_dest;
   logic              r_main_we;
   logic [bits-1:0]   r_skid_data;
   logic [DEST_W-1:0] r_skid_dest;
   logic              r_skid_we;

   logic [3:0]        r_flags;
   logic              r_err;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_legal;
   logic              w_acc;
   logic              w_ret;
   logic              w_out_valid;
   logic              w_we_in;
   logic              w_cond;

   // The ULA zero flag is deliberately ignored; Z is recomputed from RESU.
   logic              w_unused_z;
   assign w_unused_z = Z;

   // Opcode legality decode
   always_comb begin
      w_legal = 1'b0;
      case (OP)
         5'b00000, 5'b00001, 5'b00011,
         5'b00100, 5'b00101, 5'b00110: w_legal = 1'b1;
         default:                      w_legal = 1'b0;
      endcase
   end

   assign w_out_valid = (r_state == c_st_one) || (r_state == c_st_two);
   assign w_acc       = IN_VALID && r_in_ready;
   assign w_ret       = w_out_valid && OUT_READY;
   assign w_we_in     = WE_IN && w_legal;

   // Skid buffer next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_empty: if (w_acc) w_state_nxt = c_st_one;
         c_st_one: begin
            if (w_acc && !w_ret)      w_state_nxt = c_st_two;
            else if (!w_acc && w_ret) w_state_nxt = c_st_empty;
            else                      w_state_nxt = c_st_one;
         end
         c_st_two:   if (w_ret) w_state_nxt = c_st_one;
         default:    w_state_nxt = c_st_empty;
      endcase
   end

   // Buffer state, registered ready and main/skid entry storage
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= c_st_empty;
         r_in_ready  <= 1'b0;
         r_main_data <= '0;
         r_main_dest <= '0;
         r_main_we   <= 1'b0;
         r_skid_data <= '0;
         r_skid_dest <= '0;
         r_skid_we   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         // ready only depends on whether the skid entry will be occupied
         r_in_ready <= (w_state_nxt != c_st_two);
         if (w_acc && ((r_state == c_st_empty) || ((r_state == c_st_one) && w_ret))) begin
            r_main_data <= RESU;
            r_main_dest <= DEST;
            r_main_we   <= w_we_in;
         end else if ((r_state == c_st_two) && w_ret) begin
            r_main_data <= r_skid_data;
            r_main_dest <= r_skid_dest;
            r_main_we   <= r_skid_we;
         end
         if (w_acc && (r_state == c_st_one) && !w_ret) begin
            r_skid_data <= RESU;
            r_skid_dest <= DEST;
            r_skid_we   <= w_we_in;
         end
      end
   end

   // Flags update at accept time; sticky error and retire counter
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_flags <= 4'b0000;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         if (w_acc && FLAG_EN && w_legal)
            r_flags <= {O, C, S, (RESU == '0)};
         if (w_acc && !w_legal)
            r_err <= 1'b1;
         if (w_ret)
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Branch condition evaluation against registered {O,C,S,Z}
   always_comb begin
      w_cond = 1'b0;
      case (COND)
         4'd0:    w_cond = 1'b0;
         4'd1:    w_cond = r_flags[0];
         4'd2:    w_cond = !r_flags[0];
         4'd3:    w_cond = r_flags[2];
         4'd4:    w_cond = !r_flags[2];
         4'd5:    w_cond = r_flags[1];
         4'd6:    w_cond = !r_flags[1];
         4'd7:    w_cond = r_flags[3];
         4'd8:    w_cond = !r_flags[3];
         4'd9:    w_cond = (r_flags[1] != r_flags[3]);
         4'd10:   w_cond = (r_flags[1] == r_flags[3]);
         4'd11:   w_cond = !r_flags[0] && (r_flags[1] == r_flags[3]);
         4'd12:   w_cond = r_flags[0] || (r_flags[1] != r_flags[3]);
         default: w_cond = 1'b0;
      endcase
   end

   assign IN_READY  = r_in_ready;
   assign OUT_VALID = w_out_valid;
   assign WB_DATA   = r_main_data;
   assign WB_DEST   = r_main_dest;
   assign WB_WE     = r_main_we;
   assign FLAGS     = r_flags;
   assign COND_TRUE = w_cond;
   assign ERR       = r_err;
   assign OP_CNT    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ula_wb_flags.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ula_wb_flags
//  Purpose  : Directed self-checking bench for ula_wb_flags.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ula_wb_flags;

   logic        CLK = 1'b0;
   logic        RST;
   logic        IN_VALID;
   logic        IN_READY;
   logic [31:0] RESU;
   logic [4:0]  OP;
   logic        O, C, S, Z;
   logic [3:0]  DEST;
   logic        WE_IN;
   logic        FLAG_EN;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [31:0] WB_DATA;
   logic [3:0]  WB_DEST;
   logic        WB_WE;
   logic [3:0]  FLAGS;
   logic [3:0]  COND;
   logic        COND_TRUE;
   logic        ERR;
   logic [15:0] OP_CNT;

   int checks = 0;
   int errors = 0;

   ula_wb_flags #(.bits(32), .DEST_W(4), .CNT_W(16)) dut (
      .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .RESU(RESU), .OP(OP), .O(O), .C(C), .S(S), .Z(Z), .DEST(DEST),
      .WE_IN(WE_IN), .FLAG_EN(FLAG_EN), .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY), .WB_DATA(WB_DATA), .WB_DEST(WB_DEST),
      .WB_WE(WB_WE), .FLAGS(FLAGS), .COND(COND), .COND_TRUE(COND_TRUE),
      .ERR(ERR), .OP_CNT(OP_CNT)
   );

   always #5 CLK = ~CLK;

   task automatic test_reset();
      RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; RESU = '0; OP = '0;
      O = 0; C = 0; S = 0; Z = 0; DEST = '0; WE_IN = 0; FLAG_EN = 0; COND = '0;
      repeat (2) @(negedge CLK);
      checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", OUT_VALID); end
      checks++; if (WB_DATA !== 32'h0 || WB_DEST !== 4'h0 || WB_WE !== 1'b0) begin errors++; $display("FAIL rst_wb: got %h/%h/%b expected 0/0/0", WB_DATA, WB_DEST, WB_WE); end
      checks++; if (FLAGS !== 4'b0000 || ERR !== 1'b0 || OP_CNT !== 16'd0) begin errors++; $display("FAIL rst_state: flags %b err %b cnt %0d expected 0000/0/0", FLAGS, ERR, OP_CNT); end
      checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL rst_in_ready_low: got %b expected 0", IN_READY); end
      RST = 1'b0;
      @(negedge CLK);
      checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL rst_in_ready_high: got %b expected 1", IN_READY); end
   endtask

   task automatic test_single();
      IN_VALID = 1; RESU = 32'd5; OP = 5'b00000; DEST = 4'd3; WE_IN = 1; FLAG_EN = 1;
      O = 0; C = 0; S = 0; Z = 0; OUT_READY = 1;
      @(negedge CLK);
      IN_VALID = 0;
      checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", OUT_VALID); end
      checks++; if (WB_DATA !== 32'd5 || WB_DEST !== 4'd3 || WB_WE !== 1'b1) begin errors++; $display("FAIL single_wb: got %h/%h/%b expected 5/3/1", WB_DATA, WB_DEST, WB_WE); end
      checks++; if (FLAGS !== 4'b0000) begin errors++; $display("FAIL single_flags: got %b expected 0000", FLAGS); end
      @(negedge CLK);
      checks++; if (OP_CNT !== 16'd1 || OUT_VALID !== 1'b0) begin errors++; $display("FAIL single_retire: cnt %0d valid %b expected 1/0", OP_CNT, OUT_VALID); end
   endtask

   task automatic test_back_to_back();
      OUT_READY = 0; FLAG_EN = 0; OP = 5'b00000; WE_IN = 1;
      IN_VALID = 1; RESU = 32'h11; DEST = 4'd1;
      @(negedge CLK);
      checks++; if (WB_DATA !== 32'h11 || IN_READY !== 1'b1) begin errors++; $display("FAIL bp_a: data %h ready %b expected 11/1", WB_DATA, IN_READY); end
      RESU = 32'h22; DEST = 4'd2;
      @(negedge CLK);
      checks++; if (IN_READY !== 1'b0 || WB_DATA !== 32'h11 || OUT_VALID !== 1'b1) begin errors++; $display("FAIL bp_full: ready %b data %h valid %b expected 0/11/1", IN_READY, WB_DATA, OUT_VALID); end
      RESU = 32'h33; DEST = 4'd3;
      @(negedge CLK);
      checks++; if (IN_READY !== 1'b0 || WB_DATA !== 32'h11 || WB_DEST !== 4'd1 || OP_CNT !== 16'd1) begin errors++; $display("FAIL bp_hold: ready %b data %h dest %h cnt %0d expected 0/11/1/1", IN_READY, WB_DATA, WB_DEST, OP_CNT); end
      OUT_READY = 1;
      @(negedge CLK);
      checks++; if (WB_DATA !== 32'h22 || OP_CNT !== 16'd2 || IN_READY !== 1'b1) begin errors++; $display("FAIL bp_b: data %h cnt %0d ready %b expected 22/2/1", WB_DATA, OP_CNT, IN_READY); end
      @(negedge CLK);
      checks++; if (WB_DATA !== 32'h33 || WB_DEST !== 4'd3 || OP_CNT !== 16'd3) begin errors++; $display("FAIL bp_c: data %h dest %h cnt %0d expected 33/3/3", WB_DATA, WB_DEST, OP_CNT); end
      IN_VALID = 0;
      @(negedge CLK);
      checks++; if (OUT_VALID !== 1'b0 || OP_CNT !== 16'd4) begin errors++; $display("FAIL bp_drain: valid %b cnt %0d expected 0/4", OUT_VALID, OP_CNT); end
   endtask

   task automatic test_zero_flag();
      IN_VALID = 1; RESU = 32'd0; Z = 0; OP = 5'b00001; FLAG_EN = 1; O = 0; C = 1; S = 0;
      @(negedge CLK);
      checks++; if (FLAGS !== 4'b0101) begin errors++; $display("FAIL zero_flags: got %b expected 0101", FLAGS); end
      COND = 4'd1; #1;
      checks++; if (COND_TRUE !== 1'b1) begin errors++; $display("FAIL zero_cond1: got %b expected 1", COND_TRUE); end
      COND = 4'd2; #1;
      checks++; if (COND_TRUE !== 1'b0) begin errors++; $display("FAIL zero_cond2: got %b expected 0", COND_TRUE); end
      RESU = 32'd7; FLAG_EN = 0; O = 1; C = 0; S = 1;
      @(negedge CLK);
      IN_VALID = 0;
      checks++; if (FLAGS !== 4'b0101 || OP_CNT !== 16'd5) begin errors++; $display("FAIL zero_noupd: flags %b cnt %0d expected 0101/5", FLAGS, OP_CNT); end
      COND = 4'd3; #1;
      checks++; if (COND_TRUE !== 1'b1) begin errors++; $display("FAIL zero_cond3: got %b expected 1", COND_TRUE); end
      @(negedge CLK);
      checks++; if (OP_CNT !== 16'd6) begin errors++; $display("FAIL zero_cnt: got %0d expected 6", OP_CNT); end
   endtask

   task automatic test_signed_cond();
      logic [3:0] conds [8] = '{4'd9, 4'd10, 4'd11, 4'd12, 4'd7, 4'd0, 4'd13, 4'd15};
      logic       exps  [8] = '{1'b1, 1'b0,  1'b0,  1'b1,  1'b1, 1'b0, 1'b0,  1'b0};
      IN_VALID = 1; RESU = 32'h80; OP = 5'b00011; FLAG_EN = 1; O = 1; C = 0; S = 0;
      @(negedge CLK);
      IN_VALID = 0;
      checks++; if (FLAGS !== 4'b1000) begin errors++; $display("FAIL signed_flags: got %b expected 1000", FLAGS); end
      for (int i = 0; i < 8; i++) begin
         COND = conds[i]; #1;
         checks++; if (COND_TRUE !== exps[i]) begin errors++; $display("FAIL signed_cond%0d: got %b expected %b", conds[i], COND_TRUE, exps[i]); end
      end
      @(negedge CLK);
      checks++; if (OP_CNT !== 16'd7) begin errors++; $display("FAIL signed_cnt: got %0d expected 7", OP_CNT); end
   endtask

   task automatic test_illegal_op();
      IN_VALID = 1; OP = 5'b00010; WE_IN = 1; FLAG_EN = 1; RESU = 32'd9; DEST = 4'd5;
      O = 0; C = 1; S = 1;
      @(negedge CLK);
      checks++; if (WB_WE !== 1'b0 || WB_DATA !== 32'd9 || OUT_VALID !== 1'b1) begin errors++; $display("FAIL ill_wb: we %b data %h valid %b expected 0/9/1", WB_WE, WB_DATA, OUT_VALID); end
      checks++; if (ERR !== 1'b1 || FLAGS !== 4'b1000) begin errors++; $display("FAIL ill_err_flags: err %b flags %b expected 1/1000", ERR, FLAGS); end
      OP = 5'b00100; RESU = 32'd1; FLAG_EN = 0;
      @(negedge CLK);
      IN_VALID = 0;
      checks++; if (OP_CNT !== 16'd8 || WB_WE !== 1'b1 || ERR !== 1'b1) begin errors++; $display("FAIL ill_next: cnt %0d we %b err %b expected 8/1/1", OP_CNT, WB_WE, ERR); end
      @(negedge CLK);
      checks++; if (OP_CNT !== 16'd9 || ERR !== 1'b1) begin errors++; $display("FAIL ill_sticky: cnt %0d err %b expected 9/1", OP_CNT, ERR); end
   endtask

   task automatic test_reset_mid();
      OUT_READY = 0; OP = 5'b00000; FLAG_EN = 0;
      IN_VALID = 1; RESU = 32'hA;
      @(negedge CLK);
      RESU = 32'hB;
      @(negedge CLK);
      checks++; if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1) begin errors++; $display("FAIL mid_two: ready %b valid %b expected 0/1", IN_READY, OUT_VALID); end
      RST = 1; IN_VALID = 0; OUT_READY = 1;
      @(negedge CLK);
      checks++; if (OUT_VALID !== 1'b0 || OP_CNT !== 16'd0 || ERR !== 1'b0 || FLAGS !== 4'b0000 || IN_READY !== 1'b0) begin errors++; $display("FAIL mid_rst: valid %b cnt %0d err %b flags %b ready %b expected 0/0/0/0000/0", OUT_VALID, OP_CNT, ERR, FLAGS, IN_READY); end
      RST = 0;
      @(negedge CLK);
      checks++; if (OUT_VALID !== 1'b0 || OP_CNT !== 16'd0 || IN_READY !== 1'b1) begin errors++; $display("FAIL mid_after: valid %b cnt %0d ready %b expected 0/0/1", OUT_VALID, OP_CNT, IN_READY); end
   endtask

   task automatic test_cnt_wrap();
      OUT_READY = 1; OP = 5'b00000; FLAG_EN = 0; IN_VALID = 1;
      repeat (65535) @(negedge CLK);
      IN_VALID = 0;
      @(negedge CLK);
      checks++; if (OP_CNT !== 16'hFFFF || OUT_VALID !== 1'b0) begin errors++; $display("FAIL wrap_pre: cnt %0d valid %b expected 65535/0", OP_CNT, OUT_VALID); end
      IN_VALID = 1;
      @(negedge CLK);
      IN_VALID = 0;
      @(negedge CLK);
      checks++; if (OP_CNT !== 16'd0) begin errors++; $display("FAIL wrap: got %0d expected 0", OP_CNT); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_zero_flag();
      test_signed_cond();
      test_illegal_op();
      test_reset_mid();
      test_cnt_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
